register_file_16x16: RTL and testbench
======================================

REGISTER_FILE_16X16 -- requirements
Module: register_file_16x16

Interface
REQ-001 SHALL have parameter RESET_VAL, default 16'h0000; the value every register takes on reset.
REQ-002 SHALL have port CLK, input, 1 bit; the single clock, rising-edge active.
REQ-003 SHALL have port RST_N, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port WE, input, 1 bit; write enable.
REQ-005 SHALL have port WADDR, input, 4 bits; write register index.
REQ-006 SHALL have port WDATA, input, 16 bits; write data.
REQ-007 SHALL have port RE, input, 1 bit; read request for both ports.
REQ-008 SHALL have port RADDR_A, input, 4 bits; read index for port A.
REQ-009 SHALL have port RADDR_B, input, 4 bits; read index for port B.
REQ-010 SHALL have port OUT_A, output, 16 bits; registered read data for port A.
REQ-011 SHALL have port OUT_B, output, 16 bits; registered read data for port B.
REQ-012 SHALL have port RVALID, output, 1 bit; OUT_A and OUT_B hold fresh data this cycle.
REQ-013 SHALL have port DIRTY, output, 16 bits; bit i set means register i has been written since reset.

Function
REQ-014 SHALL contain 16 registers R0..R15, each 16 bits, all writable; R0 has no special behaviour.
REQ-015 SHALL write WDATA into R[WADDR] on the rising CLK edge when WE=1 and leave all other registers unchanged.
REQ-016 SHALL set DIRTY[WADDR] on the same edge as the write; DIRTY bits are cleared only by reset.
REQ-017 SHALL capture R[RADDR_A] into OUT_A and R[RADDR_B] into OUT_B on the rising edge when RE=1, a read latency of 1 cycle.
REQ-018 SHALL assert RVALID for exactly the cycle following each edge sampled with RE=1; back-to-back RE gives continuous RVALID.
REQ-019 SHALL hold OUT_A and OUT_B at their last value when RE=0.
REQ-020 SHALL bypass the write: if WE=1, RE=1 and WADDR=RADDR_A on the same edge, OUT_A SHALL take WDATA, not the old register value; the same rule applies independently to port B.
REQ-021 SHALL allow RADDR_A=RADDR_B; both outputs then return identical data, including under bypass.
REQ-022 SHALL give a write with no concurrent read the same register effect as a write with a concurrent read.
REQ-023 SHALL produce no X on any output after reset release, whatever the address values.

Reset
REQ-024 SHALL, while RST_N=0 and independent of CLK, set all registers to RESET_VAL, OUT_A=OUT_B=16'h0000, RVALID=0 and DIRTY=16'h0000.
REQ-025 SHALL treat assertion of RST_N during a write or read cycle as cancelling that operation; no register keeps a partial update.
REQ-026 SHALL ignore WE and RE on the first rising edge at which RST_N is already deasserted only if RST_N was released within setup; otherwise normal operation resumes on that edge.

Structure
REQ-027 SHALL take NUM_REGS=16, DATA_W=16 and ADDR_W=4 from the shared package rf_pkg.
REQ-028 SHALL implement each read port's selection with one instance of the existing mux_16_1_input16bit (X0..X15 connected to R0..R15, S connected to RADDR, OUT feeding the bypass mux), giving two instances in total.
REQ-029 SHALL place the bypass compare and all storage in register_file_16x16 itself; no other sub-modules.

Verification
REQ-030 Reset: RST_N=0 mid-run after writes -> OUT_A=OUT_B=0, RVALID=0, DIRTY=0, and a subsequent read of R0..R15 returns 16'h0000.
REQ-031 Walking-one: write R[i]=1<<i for i=0..15, then read pairs (A=i, B=15-i) -> OUT_A=1<<i and OUT_B=1<<(15-i) one cycle after each RE, with DIRTY=16'hFFFF.
REQ-032 Bypass: R5=16'h1111, then same edge WE=1, WADDR=5, WDATA=16'hBEEF, RE=1, RADDR_A=5, RADDR_B=5 -> OUT_A=OUT_B=16'hBEEF next cycle.
REQ-033 Hold: read R3=16'h00A5, then RE=0 for 4 cycles while writing R3=16'hFFFF -> OUT_A stays 16'h00A5 and RVALID=0; the next RE returns 16'hFFFF.
REQ-034 Async reset: assert RST_N=0 between clock edges with WE=1, WADDR=7 -> outputs clear immediately, R7 reads 16'h0000 after release, DIRTY[7]=0.
REQ-035 Back-to-back: RE=1 for 3 consecutive edges at addresses 1, 2, 3 -> RVALID high for 3 consecutive cycles with data R1, R2, R3 in order.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing and types for the 16x16 register file and its read muxes.
package rf_pkg;
  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // One-hot mask of a register index, used to mark written registers dirty.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input addr_t a);
    addr_onehot    = '0;
    addr_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/mux_16_1_input16bit.sv
// 16-to-1 multiplexer of 16-bit words, one instance per register-file read port.
module mux_16_1_input16bit
  import rf_pkg::*;
(
  input  logic [DATA_W-1:0] X0,
  input  logic [DATA_W-1:0] X1,
  input  logic [DATA_W-1:0] X2,
  input  logic [DATA_W-1:0] X3,
  input  logic [DATA_W-1:0] X4,
  input  logic [DATA_W-1:0] X5,
  input  logic [DATA_W-1:0] X6,
  input  logic [DATA_W-1:0] X7,
  input  logic [DATA_W-1:0] X8,
  input  logic [DATA_W-1:0] X9,
  input  logic [DATA_W-1:0] X10,
  input  logic [DATA_W-1:0] X11,
  input  logic [DATA_W-1:0] X12,
  input  logic [DATA_W-1:0] X13,
  input  logic [DATA_W-1:0] X14,
  input  logic [DATA_W-1:0] X15,
  input  logic [ADDR_W-1:0] S,
  output logic [DATA_W-1:0] OUT
);
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    OUT = '0;
    case (S)
      4'd0:  OUT = X0;
      4'd1:  OUT = X1;
      4'd2:  OUT = X2;
      4'd3:  OUT = X3;
      4'd4:  OUT = X4;
      4'd5:  OUT = X5;
      4'd6:  OUT = X6;
      4'd7:  OUT = X7;
      4'd8:  OUT = X8;
      4'd9:  OUT = X9;
      4'd10: OUT = X10;
      4'd11: OUT = X11;
      4'd12: OUT = X12;
      4'd13: OUT = X13;
      4'd14: OUT = X14;
      4'd15: OUT = X15;
      default: OUT = '0;
    endcase
  end
endmodule

// File: rtl/register_file_16x16.sv
// 16 x 16-bit register file: one write port, two registered read ports with
// write-to-read bypass, a read-valid strobe and per-register dirty tracking.
module register_file_16x16
  import rf_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = 16'h0000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   WADDR,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic                RE,
  input  logic [ADDR_W-1:0]   RADDR_A,
  input  logic [ADDR_W-1:0]   RADDR_B,
  output logic [DATA_W-1:0]   OUT_A,
  output logic [DATA_W-1:0]   OUT_B,
  output logic                RVALID,
  output logic [NUM_REGS-1:0] DIRTY
);
  data_t                regs_q [NUM_REGS];
  data_t                regs_d [NUM_REGS];
  data_t                out_a_q, out_a_d;
  data_t                out_b_q, out_b_d;
  logic                 rvalid_q, rvalid_d;
  logic [NUM_REGS-1:0]  dirty_q, dirty_d;
  data_t                mux_a, mux_b;

  mux_16_1_input16bit u_mux_a (
    .X0 (regs_q[0]),  .X1 (regs_q[1]),  .X2 (regs_q[2]),  .X3 (regs_q[3]),
    .X4 (regs_q[4]),  .X5 (regs_q[5]),  .X6 (regs_q[6]),  .X7 (regs_q[7]),
    .X8 (regs_q[8]),  .X9 (regs_q[9]),  .X10(regs_q[10]), .X11(regs_q[11]),
    .X12(regs_q[12]), .X13(regs_q[13]), .X14(regs_q[14]), .X15(regs_q[15]),
    .S  (RADDR_A),
    .OUT(mux_a)
  );

  mux_16_1_input16bit u_mux_b (
    .X0 (regs_q[0]),  .X1 (regs_q[1]),  .X2 (regs_q[2]),  .X3 (regs_q[3]),
    .X4 (regs_q[4]),  .X5 (regs_q[5]),  .X6 (regs_q[6]),  .X7 (regs_q[7]),
    .X8 (regs_q[8]),  .X9 (regs_q[9]),  .X10(regs_q[10]), .X11(regs_q[11]),
    .X12(regs_q[12]), .X13(regs_q[13]), .X14(regs_q[14]), .X15(regs_q[15]),
    .S  (RADDR_B),
    .OUT(mux_b)
  );

  always_comb begin
    regs_d   = regs_q;
    dirty_d  = dirty_q;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    rvalid_d = RE;

    if (WE) begin
      regs_d[WADDR] = WDATA;
      dirty_d       = dirty_q | addr_onehot(WADDR);
    end

    // A same-edge write to the addressed register wins over the stale stored value.
    if (RE) begin
      out_a_d = (WE && (WADDR == RADDR_A)) ? WDATA : mux_a;
      out_b_d = (WE && (WADDR == RADDR_B)) ? WDATA : mux_b;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the storage array is reset because a defined value after reset is part of its contract.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      out_a_q  <= '0;
      out_b_q  <= '0;
      rvalid_q <= 1'b0;
      dirty_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge _d value.
      regs_q   <= regs_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      rvalid_q <= rvalid_d;
      dirty_q  <= dirty_d;
    end
  end

  assign OUT_A  = out_a_q;
  assign OUT_B  = out_b_q;
  assign RVALID = rvalid_q;
  assign DIRTY  = dirty_q;
endmodule

// File: tb/tb_register_file_16x16.sv
// Directed bench for register_file_16x16: a reference model feeds a scoreboard
// queue of expected read pairs, popped and compared when RVALID is due.
module tb_register_file_16x16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [3:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata;
  logic [15:0] out_a, out_b, dirty;
  logic        rvalid;

  always #5 clk = ~clk;

  register_file_16x16 #(.RESET_VAL(16'h0000)) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .WE     (we),
    .WADDR  (waddr),
    .WDATA  (wdata),
    .RE     (re),
    .RADDR_A(raddr_a),
    .RADDR_B(raddr_b),
    .OUT_A  (out_a),
    .OUT_B  (out_b),
    .RVALID (rvalid),
    .DIRTY  (dirty)
  );

  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_regs [16];
  logic [15:0] m_dirty;
  logic [15:0] last_a, last_b;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_dirty = 16'h0000;
    last_a  = 16'h0000;
    last_b  = 16'h0000;
    sb.delete();
  endtask

  // Drive one cycle's inputs, advance past the edge, then check every output.
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [15:0] wd,
                       input logic r, input logic [3:0] ra, input logic [3:0] rb);
    logic [15:0] ea, eb;
    logic [31:0] exp;
    we = w; waddr = wa; wdata = wd; re = r; raddr_a = ra; raddr_b = rb;
    if (r) begin
      ea = (w && wa == ra) ? wd : m_regs[ra];
      eb = (w && wa == rb) ? wd : m_regs[rb];
      sb.push_back({ea, eb});
    end
    if (w) begin
      m_regs[wa]  = wd;
      m_dirty[wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rvalid", {31'b0, rvalid}, {31'b0, r});
    if (r) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp = sb.pop_front();
        check("out_a", {16'b0, out_a}, {16'b0, exp[31:16]});
        check("out_b", {16'b0, out_b}, {16'b0, exp[15:0]});
        last_a = exp[31:16];
        last_b = exp[15:0];
      end
    end else begin
      check("hold_a", {16'b0, out_a}, {16'b0, last_a});
      check("hold_b", {16'b0, out_b}, {16'b0, last_b});
    end
    check("dirty", {16'b0, dirty}, {16'b0, m_dirty});
  endtask

  initial begin
    logic [15:0] one;
    one = 16'h0001;
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr_a = '0; raddr_b = '0; wdata = '0;
    model_reset();

    // Outputs must be clear while reset is held, before any clock edge.
    #2;
    check("rst_out_a", {16'b0, out_a}, 32'h0);
    check("rst_out_b", {16'b0, out_b}, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_dirty", {16'b0, dirty}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Walking one: R[i] = 1<<i, then read pairs (i, 15-i).
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), one << i, 1'b0, 4'd0, 4'd0);
    check("walk_dirty_full", {16'b0, dirty}, 32'h0000FFFF);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 4'(15 - i));
      check("walk_a_const", {16'b0, out_a}, {16'b0, one << i});
      check("walk_b_const", {16'b0, out_b}, {16'b0, one << (15 - i)});
    end
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);

    // Bypass on both ports reading the register being written.
    cycle(1'b1, 4'd5, 16'h1111, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 4'd5, 16'hBEEF, 1'b1, 4'd5, 4'd5);
    check("bypass_a_const", {16'b0, out_a}, 32'h0000BEEF);
    check("bypass_b_const", {16'b0, out_b}, 32'h0000BEEF);
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);

    // Hold: outputs freeze while RE=0 even as the read register changes.
    cycle(1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd3);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'd3, 16'hFFFF, 1'b0, 4'd0, 4'd0);
      check("hold_a_const", {16'b0, out_a}, 32'h000000A5);
    end
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd0);
    check("hold_reread_const", {16'b0, out_a}, 32'h0000FFFF);

    // Back-to-back reads of R1, R2, R3.
    cycle(1'b1, 4'd1, 16'h0101, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 4'd2, 16'h0202, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd1);
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 4'd1);
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd2);
    check("b2b_last_const", {16'b0, out_a}, 32'h0000FFFF);
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);

    // Async reset between edges during a write to R7 with a read pending.
    we = 1'b1; waddr = 4'd7; wdata = 16'h7777; re = 1'b1; raddr_a = 4'd7; raddr_b = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_a", {16'b0, out_a}, 32'h0);
    check("async_out_b", {16'b0, out_b}, 32'h0);
    check("async_rvalid", {31'b0, rvalid}, 32'h0);
    check("async_dirty", {16'b0, dirty}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0; re = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 4'(15 - i));
      check("post_rst_zero", {16'b0, out_a | out_b}, 32'h0);
    end
    cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    check("post_rst_dirty7", {31'b0, dirty[7]}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
